// File: rtl/audio_buffer_if.sv
// Sample-buffer handshake bundle between the control FSM / ADC / DAC side (master)
// and audio_buffer_ctrl (slave).
interface audio_buffer_if #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 16384
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic              enable_write;
   logic              enable_read;
   logic              sample_tick;
   logic [DATA_W-1:0] sample_in;
   logic [DATA_W-1:0] sample_out;
   logic              sample_out_valid;
   logic              rec_done;
   logic              play_done;
   logic              busy;
   logic [ADDR_W:0]   rec_len;

   modport master (
      output enable_write, enable_read, sample_tick, sample_in,
      input  sample_out, sample_out_valid, rec_done, play_done, busy, rec_len
   );

   modport slave (
      input  enable_write, enable_read, sample_tick, sample_in,
      output sample_out, sample_out_valid, rec_done, play_done, busy, rec_len
   );
endinterface

// File: rtl/audio_buffer_ctrl.sv
// Record/playback sample buffer with inferred RAM and registered read port.
// Optional build macro LOOP_PLAY_EN: playback wraps and repeats while enable_read stays high.
module audio_buffer_ctrl #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 16384
) (
   input  logic           clk,
   input  logic           reset,
   audio_buffer_if.slave  bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   LEN_FULL = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_REC, ST_PLAY, ST_HOLD} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   rec_len_q, rec_len_d;
   logic              rec_done_q, rec_done_d;
   logic              play_done_q, play_done_d;
   logic              valid_q;
   logic [DATA_W-1:0] sample_out_q;
   logic              wr_en, rd_en;
   logic              rd_last;

   logic [DATA_W-1:0] mem [DEPTH];

   assign rd_last = ({1'b0, addr_q} == (rec_len_q - LEN_ONE));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rec_len_d   = rec_len_q;
      rec_done_d  = 1'b0;
      play_done_d = 1'b0;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.enable_write) begin
               state_d = ST_REC;
               addr_d  = '0;
            end else if (bus.enable_read) begin
               state_d = ST_PLAY;
               addr_d  = '0;
            end
         end
         ST_REC: begin
            // An early drop wins over a tick arriving in the same cycle.
            if (!bus.enable_write) begin
               rec_len_d  = {1'b0, addr_q};
               rec_done_d = 1'b1;
               state_d    = ST_IDLE;
            end else if (bus.sample_tick) begin
               wr_en = 1'b1;
               if (addr_q == ADDR_MAX) begin
                  rec_len_d  = LEN_FULL;
                  rec_done_d = 1'b1;
                  state_d    = ST_HOLD;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         ST_PLAY: begin
            if (!bus.enable_read) begin
               state_d = ST_IDLE;
            end else if (rec_len_q == '0) begin
`ifndef LOOP_PLAY_EN
               play_done_d = 1'b1;
               state_d     = ST_HOLD;
`endif
            end else if (bus.sample_tick) begin
               rd_en       = 1'b1;
               play_done_d = rd_last;
               if (rd_last) begin
`ifdef LOOP_PLAY_EN
                  addr_d  = '0;
`else
                  state_d = ST_HOLD;
`endif
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (!bus.enable_write && !bus.enable_read) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rec_len_q   <= '0;
         rec_done_q  <= 1'b0;
         play_done_q <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rec_len_q   <= rec_len_d;
         rec_done_q  <= rec_done_d;
         play_done_q <= play_done_d;
         valid_q     <= rd_en;
      end
   end

   // RAM array carries no reset so it maps onto block memory.
   always_ff @(posedge clk) begin
      if (wr_en) mem[addr_q] <= bus.sample_in;
   end

   always_ff @(posedge clk) begin
      if (!reset)     sample_out_q <= '0;
      else if (rd_en) sample_out_q <= mem[addr_q];
   end

   assign bus.sample_out       = sample_out_q;
   assign bus.sample_out_valid = valid_q;
   assign bus.rec_done         = rec_done_q;
   assign bus.play_done        = play_done_q;
   assign bus.busy             = (state_q == ST_REC) || (state_q == ST_PLAY);
   assign bus.rec_len          = rec_len_q;
endmodule

// File: tb/tb_audio_buffer_ctrl.sv
// Scoreboard bench for audio_buffer_ctrl (DEPTH=8, DATA_W=12, tick every 4 cycles).
module tb_audio_buffer_ctrl;
   localparam int DATA_W = 12;
   localparam int DEPTH  = 8;

   typedef struct {
      logic [31:0] v;
      logic        last;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   exp_t play_q[$];
   exp_t rec_q[$];
   int   empty_q[$];

   audio_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   audio_buffer_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_evt(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
   endtask

   // Monitor: compare DUT events against the scoreboard queues.
   always @(negedge clk) begin
      exp_t e;
      int   c;
      if (reset) begin
         if (bus.rec_done) begin
            if (rec_q.size() == 0) fail_evt("rec_done_unexpected");
            else begin
               e = rec_q.pop_front();
               chk("rec_len", 32'(bus.rec_len), e.v);
               chk("rec_done_cycle", cyc, e.cyc);
            end
         end
         if (bus.sample_out_valid) begin
            if (play_q.size() == 0) fail_evt("valid_unexpected");
            else begin
               e = play_q.pop_front();
               chk("sample_out", 32'(bus.sample_out), e.v);
               chk("play_done_flag", 32'(bus.play_done), 32'(e.last));
               chk("valid_cycle", cyc, e.cyc);
            end
         end else if (bus.play_done) begin
            if (empty_q.size() == 0) fail_evt("play_done_unexpected");
            else begin
               c = empty_q.pop_front();
               chk("empty_play_done_cycle", cyc, c);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic [DATA_W-1:0] val);
      bus.sample_tick = 1'b1;
      bus.sample_in   = val;
      step();
      bus.sample_tick = 1'b0;
      repeat (3) step();
   endtask

   task automatic play_tick(input logic [DATA_W-1:0] val, input logic last);
      play_q.push_back('{32'(val), last, cyc + 1});
      tick(val);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.enable_write = 1'b0;
      bus.enable_read  = 1'b0;
      bus.sample_tick  = 1'b0;
      bus.sample_in    = '0;

      // 1: reset with toggling inputs
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.enable_write = 1'($urandom_range(0, 1));
         bus.enable_read  = 1'($urandom_range(0, 1));
         bus.sample_tick  = 1'($urandom_range(0, 1));
         bus.sample_in    = 12'($urandom());
         step();
      end
      bus.enable_write = 1'b0;
      bus.enable_read  = 1'b0;
      bus.sample_tick  = 1'b0;
      bus.sample_in    = '0;
      chk("rst_sample_out", 32'(bus.sample_out), 0);
      chk("rst_valid", 32'(bus.sample_out_valid), 0);
      chk("rst_rec_done", 32'(bus.rec_done), 0);
      chk("rst_play_done", 32'(bus.play_done), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_rec_len", 32'(bus.rec_len), 0);
      reset = 1'b1;
      step();

      // 2: full recording of 8 samples
      bus.enable_write = 1'b1;
      step();
      chk("rec_busy", 32'(bus.busy), 1);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) rec_q.push_back('{32'd8, 1'b0, cyc + 1});
         tick(12'(12'h101 + i));
      end
      chk("hold_busy", 32'(bus.busy), 0);
      repeat (4) step();
      chk("hold_stays", 32'(bus.busy), 0);
      chk("full_rec_len", 32'(bus.rec_len), 8);
      bus.enable_write = 1'b0;
      step();

      // 3: full playback
      bus.enable_read = 1'b1;
      step();
      chk("play_busy", 32'(bus.busy), 1);
      for (int i = 0; i < 8; i++) play_tick(12'(12'h101 + i), i == 7);
      chk("play_hold_busy", 32'(bus.busy), 0);
      bus.enable_read = 1'b0;
      step();

      // 4: short recording, drop coincides with a discarded tick
      bus.enable_write = 1'b1;
      step();
      tick(12'h0AA);
      tick(12'h0BB);
      tick(12'h0CC);
      rec_q.push_back('{32'd3, 1'b0, cyc + 1});
      bus.enable_write = 1'b0;
      bus.sample_tick  = 1'b1;
      bus.sample_in    = 12'h0DD;
      step();
      bus.sample_tick = 1'b0;
      repeat (2) step();
      chk("short_busy", 32'(bus.busy), 0);
      bus.enable_read = 1'b1;
      step();
`ifdef LOOP_PLAY_EN
      // 6: looping playback over a 3-sample recording
      for (int i = 0; i < 7; i++) begin
         case (i % 3)
            0:       play_tick(12'h0AA, 1'b0);
            1:       play_tick(12'h0BB, 1'b0);
            default: play_tick(12'h0CC, 1'b1);
         endcase
      end
      chk("loop_still_busy", 32'(bus.busy), 1);
      chk("loop_hold_out", 32'(bus.sample_out), 32'h0AA);
`else
      play_tick(12'h0AA, 1'b0);
      play_tick(12'h0BB, 1'b0);
      play_tick(12'h0CC, 1'b1);
      chk("short_play_hold", 32'(bus.busy), 0);
      chk("sample_out_holds", 32'(bus.sample_out), 32'h0CC);
`endif
      bus.enable_read = 1'b0;
      step();
      chk("idle_busy", 32'(bus.busy), 0);

      // 5: both enables -> REC; reset mid-REC; empty playback
      bus.enable_write = 1'b1;
      bus.enable_read  = 1'b1;
      step();
      chk("both_busy", 32'(bus.busy), 1);
      tick(12'h333);
      reset = 1'b0;
      bus.enable_write = 1'b0;
      bus.enable_read  = 1'b0;
      step();
      chk("abort_rec_len", 32'(bus.rec_len), 0);
      chk("abort_busy", 32'(bus.busy), 0);
      reset = 1'b1;
      step();
      bus.enable_read = 1'b1;
`ifndef LOOP_PLAY_EN
      empty_q.push_back(cyc + 2);
`endif
      step();
      repeat (5) step();
`ifdef LOOP_PLAY_EN
      chk("empty_loop_busy", 32'(bus.busy), 1);
`else
      chk("empty_hold_busy", 32'(bus.busy), 0);
`endif
      bus.enable_read = 1'b0;
      repeat (3) step();

      chk("play_q_drained", play_q.size(), 0);
      chk("rec_q_drained", rec_q.size(), 0);
      chk("empty_q_drained", empty_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
